// File: rtl/async_cpu_pkg.sv
// Shared types for the async CPU pipeline inter-stage links.
//   hs_in_state_t  : producer-side 4-phase handshake states
//   hs_out_state_t : consumer-side 4-phase handshake states
package async_cpu_pkg;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } hs_in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_REQ  = 2'd1,
    OUT_WAIT = 2'd2
  } hs_out_state_t;

endpackage

// File: rtl/hs_fifo_mem.sv
// Storage for hs_stage_buffer: circular array with registered occupancy flags.
//   clk, rst (sync, active-low)
//   push/wdata : write wdata at the write pointer
//   pop/rdata  : rdata always shows the entry at the read pointer; pop advances it
//   clr        : empties the queue (pointers and count to zero), overrides push/pop
//   count/full/empty : registered occupancy
module hs_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Payload storage carries no reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/hs_stage_buffer.sv
// Elastic inter-stage buffer between 4-phase req/ack channels (IF->ID, ID->ALU, ALU->WB).
//   clk, rst (sync, active-low), flush (sync discard of queued/in-flight words)
//   in_req/in_data/in_ack    : producer channel
//   out_req/out_data/out_ack : consumer channel, out_data registered
//   count/full/empty         : stored entries, not counting the word on out_data
module hs_stage_buffer
  import async_cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_req,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ack,
  output logic                       out_req,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  hs_in_state_t     in_state_q, in_state_d;
  hs_out_state_t    out_state_q, out_state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push, pop;
  logic [WIDTH-1:0] rdata;
  logic             fifo_full, fifo_empty;

  hs_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clr   (flush),
    .wdata (in_data),
    .rdata (rdata),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Producer side. During flush a pending request is still acknowledged so
  // the producer's handshake completes, but the word is dropped.
  always_comb begin
    in_state_d = in_state_q;
    push       = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (in_req) begin
          if (flush) begin
            in_state_d = IN_ACK;
          end else if (!fifo_full) begin
            push       = 1'b1;
            in_state_d = IN_ACK;
          end
        end
      end
      IN_ACK: begin
        if (!in_req) in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  // Consumer side. Flush withdraws a presented word by moving to OUT_WAIT,
  // which still waits for out_ack low before the next issue.
  always_comb begin
    out_state_d = out_state_q;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (!fifo_empty && !flush) begin
          pop         = 1'b1;
          out_data_d  = rdata;
          out_state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (flush || out_ack) out_state_d = OUT_WAIT;
      end
      OUT_WAIT: begin
        if (!out_ack) out_state_d = OUT_IDLE;
      end
      default: out_state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      out_data_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ack   = (in_state_q == IN_ACK);
  assign out_req  = (out_state_q == OUT_REQ);
  assign out_data = out_data_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;

  // The producer may only withdraw its request once it has been acknowledged.
  a_in_req_held: assert property (@(posedge clk) disable iff (!rst)
    $fell(in_req) |-> in_ack);

  // The storage is never written while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    push |-> !fifo_full);

endmodule

// File: tb/tb_hs_stage_buffer.sv
module tb_hs_stage_buffer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst, flush, in_req, out_ack;
  logic [WIDTH-1:0] in_data, out_data;
  logic             in_ack, out_req, full, empty;
  logic [CW-1:0]    count;

  int vectors = 0;
  int errs    = 0;

  // consumer controls
  logic cons_en   = 1'b0;
  logic cons_rand = 1'b0;
  int   cons_dly  = 0;
  logic [WIDTH-1:0] got[$];

  hs_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
    $fatal(1);
  end

  // 4-phase consumer: acks a presented word after a delay, logs the word,
  // releases ack once out_req has dropped.
  initial begin : consumer
    int wait_cnt;
    int cur_dly;
    wait_cnt = 0;
    cur_dly  = 0;
    out_ack  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        out_ack  = 1'b0;
        wait_cnt = 0;
      end else if (out_ack) begin
        if (!out_req) out_ack = 1'b0;
      end else if (out_req && cons_en) begin
        if (wait_cnt == 0) cur_dly = cons_rand ? int'($urandom_range(3, 0)) : cons_dly;
        if (wait_cnt >= cur_dly) begin
          out_ack  = 1'b1;
          got.push_back(out_data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [WIDTH-1:0] d);
    int n;
    in_data = d;
    in_req  = 1'b1;
    n = 0;
    while (!in_ack && n < 200) begin tick(); n++; end
    chk("put_ack", 32'(in_ack), 32'd1);
    in_req = 1'b0;
    n = 0;
    while (in_ack && n < 20) begin tick(); n++; end
    chk("put_release", 32'(in_ack), 32'd0);
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 300) begin tick(); k++; end
    chk("got_count", 32'(got.size()), 32'(n));
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               dly;
    logic [WIDTH-1:0] exp_data;
    int               exp_cnt;
  } vec_t;

  vec_t             tbl[5];
  logic [WIDTH-1:0] exp_q[$];

  initial begin : main
    int base;
    int n;
    tbl[0] = '{16'hA5A5, 3, 16'hA5A5, 0};
    tbl[1] = '{16'h0000, 0, 16'h0000, 0};
    tbl[2] = '{16'hFFFF, 1, 16'hFFFF, 0};
    tbl[3] = '{16'h8001, 2, 16'h8001, 0};
    tbl[4] = '{16'h1234, 3, 16'h1234, 0};

    // T1 reset with a pending request
    rst = 1'b0; flush = 1'b0; in_req = 1'b1; in_data = 16'hDEAD;
    tick(); tick();
    chk("rst_in_ack",   32'(in_ack),   32'd0);
    chk("rst_out_req",  32'(out_req),  32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    in_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Latency: ack one edge after request, out_req one edge later
    cons_en = 1'b0;
    in_data = 16'h5A5A; in_req = 1'b1;
    tick();
    chk("lat_in_ack",   32'(in_ack),  32'd1);
    chk("lat_out_req0", 32'(out_req), 32'd0);
    chk("lat_count1",   32'(count),   32'd1);
    in_req = 1'b0;
    tick();
    chk("lat_out_req1", 32'(out_req),  32'd1);
    chk("lat_out_data", 32'(out_data), 32'h5A5A);
    chk("lat_count0",   32'(count),    32'd0);
    base = got.size();
    cons_en = 1'b1; cons_dly = 0;
    wait_got(base + 1);
    repeat (3) tick();

    // T2 table: single words with various consumer delays
    for (int i = 0; i < 5; i++) begin
      cons_en = 1'b1; cons_dly = tbl[i].dly;
      base = got.size();
      put(tbl[i].data);
      wait_got(base + 1);
      if (got.size() > base) chk("vec_word", 32'(got[base]), 32'(tbl[i].exp_data));
      tick();
      chk("vec_req_fall", 32'(out_req),  32'd0);
      chk("vec_hold",     32'(out_data), 32'(tbl[i].exp_data));
      tick(); tick();
      chk("vec_count",    32'(count),    32'(tbl[i].exp_cnt));
      chk("vec_empty",    32'(empty),    32'd1);
    end

    // T3 fill with stalled consumer
    cons_en = 1'b0;
    base = got.size();
    for (int i = 0; i < 5; i++) put(16'h3000 + 16'(i));
    chk("fill_count",    32'(count),    32'd4);
    chk("fill_full",     32'(full),     32'd1);
    chk("fill_empty",    32'(empty),    32'd0);
    chk("fill_out_req",  32'(out_req),  32'd1);
    chk("fill_out_data", 32'(out_data), 32'h3000);
    in_data = 16'h3005; in_req = 1'b1;
    repeat (5) tick();
    chk("fill_stall",    32'(in_ack),   32'd0);
    chk("fill_count_st", 32'(count),    32'd4);
    cons_en = 1'b1; cons_dly = 0;
    n = 0;
    while (!in_ack && n < 30) begin tick(); n++; end
    chk("fill_unstall", 32'(in_ack), 32'd1);
    in_req = 1'b0;
    tick();
    wait_got(base + 6);
    for (int i = 0; i < 6; i++)
      if (got.size() > base + i) chk("fill_order", 32'(got[base+i]), 32'h3000 + 32'(i));
    repeat (3) tick();

    // T5 flush with 3 queued plus 1 presented
    cons_en = 1'b0;
    base = got.size();
    for (int i = 0; i < 4; i++) put(16'h5000 + 16'(i));
    chk("fl_pre_count", 32'(count),   32'd3);
    chk("fl_pre_req",   32'(out_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_out_req",  32'(out_req),  32'd0);
    chk("fl_count",    32'(count),    32'd0);
    chk("fl_empty",    32'(empty),    32'd1);
    chk("fl_out_data", 32'(out_data), 32'h5000);
    tick();
    chk("fl_idle_req", 32'(out_req),  32'd0);
    put(16'h0001);
    cons_en = 1'b1; cons_dly = 1;
    wait_got(base + 1);
    if (got.size() > base) chk("fl_next_word", 32'(got[base]), 32'h0001);
    repeat (4) tick();
    chk("fl_no_extra", 32'(got.size()), 32'(base + 1));

    // T6 flush while a request waits in IN_IDLE
    cons_en = 1'b0;
    base = got.size();
    in_data = 16'hBEEF; in_req = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f6_in_ack", 32'(in_ack), 32'd1);
    chk("f6_count",  32'(count),  32'd0);
    chk("f6_empty",  32'(empty),  32'd1);
    in_req = 1'b0;
    tick();
    chk("f6_ack_rel", 32'(in_ack),  32'd0);
    tick();
    chk("f6_no_req",  32'(out_req), 32'd0);
    cons_en = 1'b1; cons_dly = 0;
    put(16'h0002);
    wait_got(base + 1);
    if (got.size() > base) chk("f6_next_word", 32'(got[base]), 32'h0002);
    repeat (4) tick();
    chk("f6_no_extra", 32'(got.size()), 32'(base + 1));

    // T4 randomized traffic against an in-order queue model
    cons_en = 1'b1; cons_rand = 1'b1;
    base = got.size();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [WIDTH-1:0] d;
          d = WIDTH'($urandom);
          put(d);
          exp_q.push_back(d);
          repeat ($urandom_range(2, 0)) tick();
        end
      end
      begin
        int k;
        k = 0;
        while (got.size() < base + 20 && k < 3000) begin
          tick(); k++;
          chk("rnd_cnt_le_depth", 32'(count <= CW'(DEPTH)), 32'd1);
          chk("rnd_full",  32'(full),  32'(count == CW'(DEPTH)));
          chk("rnd_empty", 32'(empty), 32'(count == '0));
        end
      end
    join
    chk("rnd_total", 32'(got.size()), 32'(base + 20));
    for (int i = 0; i < 20; i++)
      if (got.size() > base + i && exp_q.size() > i)
        chk("rnd_word", 32'(got[base+i]), 32'(exp_q[i]));
    repeat (4) tick();
    chk("rnd_drained", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
